// File: rtl/noc_pkg.sv
// Shared definitions for the NoC network-interface blocks: flit layout,
// header fields and the ejection FSM state type.
package noc_pkg;

    localparam int unsigned FLIT_W    = 9;
    localparam int unsigned VALID_BIT = 8;

    // Header flit body layout
    localparam int unsigned TAG_HI = 7;
    localparam int unsigned TAG_LO = 4;
    localparam int unsigned SRC_HI = 3;
    localparam int unsigned SRC_LO = 0;

    localparam logic [3:0] HDR_TAG = 4'hF;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word fall-through FIFO. A push into a full FIFO is
// accepted only when a pop retires the head in the same cycle; a pop on an
// empty FIFO is ignored. The output reads as zero while empty.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the output is gated by empty
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_flit_depacketizer.sv
// Ejection-side network interface: validates a header flit, reassembles four
// payload flits LSB-first into a 32-bit word tagged with its source node and
// queues the result for the IP core behind a valid/ready handshake.
module noc_flit_depacketizer
    import noc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              err_clr,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [3:0]        out_src,
    output logic              out_valid,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic              err_proto
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned FIFO_W = WORD_W + 4;

    state_e      r_state, w_state_d;
    logic [3:0]  r_src, w_src_d;
    logic [23:0] r_bytes, w_bytes_d;
    logic [1:0]  r_cnt, w_cnt_d;
    logic [7:0]  r_timer, w_timer_d;
    logic        r_err_ovf, r_err_tmo, r_err_pro;

    logic              w_flit_vld;
    logic [7:0]        w_body;
    logic              w_push;
    logic [WORD_W-1:0] w_word;
    logic              w_tmo_evt;
    logic              w_pro_evt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FIFO_W-1:0] w_fifo_out;

    assign w_flit_vld = in_flit[VALID_BIT];
    assign w_body     = in_flit[7:0];
    assign w_pop      = out_valid && out_ready;

    // Next-state logic for header validation, byte collection and idle timeout
    always_comb begin
        w_state_d = r_state;
        w_src_d   = r_src;
        w_bytes_d = r_bytes;
        w_cnt_d   = r_cnt;
        w_timer_d = r_timer;
        w_push    = 1'b0;
        w_word    = {w_body, r_bytes};
        w_tmo_evt = 1'b0;
        w_pro_evt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_flit_vld) begin
                    if (in_flit[TAG_HI:TAG_LO] == HDR_TAG) begin
                        w_src_d   = in_flit[SRC_HI:SRC_LO];
                        w_cnt_d   = '0;
                        w_timer_d = '0;
                        w_state_d = COLLECT;
                    end else begin
                        w_pro_evt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_flit_vld) begin
                    // Any valid flit here is payload, even one that looks like a header
                    w_timer_d = '0;
                    if (r_cnt == 2'd3) begin
                        w_push    = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = IDLE;
                    end else begin
                        case (r_cnt)
                            2'd0:    w_bytes_d[7:0]   = w_body;
                            2'd1:    w_bytes_d[15:8]  = w_body;
                            default: w_bytes_d[23:16] = w_body;
                        endcase
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end else if (r_timer == 8'(TIMEOUT - 1)) begin
                    // This idle cycle brings the timer to TIMEOUT: abandon the packet
                    w_tmo_evt = 1'b1;
                    w_cnt_d   = '0;
                    w_timer_d = '0;
                    w_state_d = IDLE;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // FSM and collection registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_bytes <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_d;
            r_src   <= w_src_d;
            r_bytes <= w_bytes_d;
            r_cnt   <= w_cnt_d;
            r_timer <= w_timer_d;
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_pro <= 1'b0;
        end else begin
            r_err_ovf <= (r_err_ovf && !err_clr) || (w_push && w_full && !w_pop);
            r_err_tmo <= (r_err_tmo && !err_clr) || w_tmo_evt;
            r_err_pro <= (r_err_pro && !err_clr) || w_pro_evt;
        end
    end

    noc_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_src, w_word}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid    = !w_empty;
    assign out_src      = w_fifo_out[FIFO_W-1:WORD_W];
    assign out_data     = w_fifo_out[WORD_W-1:0];
    assign busy         = (r_state == COLLECT);
    assign err_overflow = r_err_ovf;
    assign err_timeout  = r_err_tmo;
    assign err_proto    = r_err_pro;

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// Directed self-checking bench for noc_flit_depacketizer.
module tb_noc_flit_depacketizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  in_flit;
    logic        err_clr;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_src;
    logic        out_valid;
    logic        busy;
    logic        err_overflow;
    logic        err_timeout;
    logic        err_proto;

    int          n_chk = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          tog_en = 1'b0;
    int          rd_idx = 0;
    logic [31:0] exp_w [10];
    logic [3:0]  exp_s [10];

    always #5 clk = ~clk;

    noc_flit_depacketizer #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_flit      (in_flit),
        .err_clr      (err_clr),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_valid    (out_valid),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_proto    (err_proto)
    );

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; optionally scoreboard words popped at this edge
    task automatic step();
        if (mon_en && out_valid && out_ready) begin
            if (rd_idx < 10) begin
                check_eq("b2b_data", 36'(out_data), 36'(exp_w[rd_idx]));
                check_eq("b2b_src", 36'(out_src), 36'(exp_s[rd_idx]));
            end else begin
                check_eq("b2b_extra_word", 36'(rd_idx), 36'd9);
            end
            rd_idx++;
        end
        @(posedge clk);
        #1;
        if (tog_en) out_ready = ~out_ready;
    endtask

    task automatic send(input logic [8:0] f);
        in_flit = f;
        step();
    endtask

    task automatic idle(input int n);
        in_flit = 9'h000;
        repeat (n) step();
    endtask

    task automatic send_pkt(input logic [3:0] s, input logic [31:0] w);
        send({1'b1, 4'hF, s});
        for (int k = 0; k < 4; k++) send({1'b1, w[8*k +: 8]});
    endtask

    task automatic clear_errs();
        in_flit = 9'h000;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    // Pop n words, checking each head against exp_w/exp_s starting at first
    task automatic drain(input int first, input int n);
        in_flit = 9'h000;
        for (int i = first; i < first + n; i++) begin
            check_eq("drain_valid", 36'(out_valid), 36'd1);
            check_eq("drain_data", 36'(out_data), 36'(exp_w[i]));
            check_eq("drain_src", 36'(out_src), 36'(exp_s[i]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check_eq("drain_empty", 36'(out_valid), 36'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_flit   = 9'h000;
        err_clr   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_valid", 36'(out_valid), 36'd0);
        check_eq("rst_data", 36'(out_data), 36'd0);
        check_eq("rst_src", 36'(out_src), 36'd0);
        check_eq("rst_busy", 36'(busy), 36'd0);
        check_eq("rst_errs", 36'({err_overflow, err_timeout, err_proto}), 36'd0);

        // Basic packet
        out_ready = 1'b1;
        send(9'h1F3);
        check_eq("basic_busy", 36'(busy), 36'd1);
        send(9'h178);
        send(9'h156);
        send(9'h134);
        check_eq("basic_not_yet", 36'(out_valid), 36'd0);
        send(9'h112);
        check_eq("basic_valid", 36'(out_valid), 36'd1);
        check_eq("basic_data", 36'(out_data), 36'h12345678);
        check_eq("basic_src", 36'(out_src), 36'd3);
        check_eq("basic_idle", 36'(busy), 36'd0);
        idle(1);
        check_eq("basic_popped", 36'(out_valid), 36'd0);

        // 7-cycle gap stays within the timeout
        send(9'h1F5);
        send(9'h1DD);
        send(9'h1CC);
        idle(7);
        check_eq("gap_busy", 36'(busy), 36'd1);
        send(9'h1BB);
        send(9'h1AA);
        check_eq("gap_valid", 36'(out_valid), 36'd1);
        check_eq("gap_data", 36'(out_data), 36'hAABBCCDD);
        check_eq("gap_src", 36'(out_src), 36'd5);
        idle(1);
        check_eq("gap_no_tmo", 36'(err_timeout), 36'd0);

        // 15-cycle gap discards the packet on the 15th idle cycle
        send(9'h1F2);
        send(9'h111);
        send(9'h122);
        idle(14);
        check_eq("tmo_busy_14", 36'(busy), 36'd1);
        check_eq("tmo_flag_14", 36'(err_timeout), 36'd0);
        idle(1);
        check_eq("tmo_busy_15", 36'(busy), 36'd0);
        check_eq("tmo_flag_15", 36'(err_timeout), 36'd1);
        check_eq("tmo_no_word", 36'(out_valid), 36'd0);
        send_pkt(4'd7, 32'h0BADF00D);
        check_eq("tmo_after_data", 36'(out_data), 36'h0BADF00D);
        check_eq("tmo_after_src", 36'(out_src), 36'd7);
        idle(1);
        clear_errs();
        check_eq("tmo_cleared", 36'(err_timeout), 36'd0);

        // Protocol error, clear, and clear colliding with a new error
        send(9'h1A5);
        check_eq("proto_flag", 36'(err_proto), 36'd1);
        check_eq("proto_idle", 36'(busy), 36'd0);
        clear_errs();
        check_eq("proto_clr", 36'(err_proto), 36'd0);
        err_clr = 1'b1;
        send(9'h1A5);
        err_clr = 1'b0;
        check_eq("proto_clr_race", 36'(err_proto), 36'd1);
        clear_errs();

        // Overflow: fifth word dropped while the IP stalls
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = 32'(32'h01010101 * (i + 1)) ^ 32'h5A000000;
            exp_s[i] = 4'(i + 1);
        end
        for (int i = 0; i < 5; i++) send_pkt(exp_s[i], exp_w[i]);
        idle(1);
        check_eq("ovf_flag", 36'(err_overflow), 36'd1);
        drain(0, 4);
        clear_errs();
        check_eq("ovf_cleared", 36'(err_overflow), 36'd0);

        // Push into full FIFO alongside a pop is accepted
        for (int i = 0; i < 4; i++) send_pkt(exp_s[i], exp_w[i]);
        send({1'b1, 4'hF, exp_s[4]});
        for (int k = 0; k < 3; k++) send({1'b1, exp_w[4][8*k +: 8]});
        out_ready = 1'b1;
        send({1'b1, exp_w[4][31:24]});
        out_ready = 1'b0;
        check_eq("full_pop_no_ovf", 36'(err_overflow), 36'd0);
        drain(1, 4);

        // Back-to-back packets with toggling ready; pointers wrap
        for (int i = 0; i < 10; i++) begin
            exp_w[i] = 32'hC0DE0000 | 32'(i * 32'h00011101);
            exp_s[i] = 4'(i % 9);
        end
        rd_idx    = 0;
        mon_en    = 1'b1;
        tog_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_pkt(exp_s[i], exp_w[i]);
        in_flit = 9'h000;
        for (int c = 0; c < 60 && rd_idx < 10; c++) step();
        mon_en    = 1'b0;
        tog_en    = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_count", 36'(rd_idx), 36'd10);
        check_eq("b2b_no_ovf", 36'(err_overflow), 36'd0);
        check_eq("b2b_empty", 36'(out_valid), 36'd0);

        // Reset mid-packet with a word pending
        send_pkt(4'd6, 32'hFEEDBEEF);
        send(9'h1F4);
        send(9'h101);
        send(9'h102);
        check_eq("mid_busy", 36'(busy), 36'd1);
        check_eq("mid_pending", 36'(out_valid), 36'd1);
        rst     = 1'b1;
        in_flit = 9'h000;
        step();
        rst = 1'b0;
        check_eq("mid_rst_busy", 36'(busy), 36'd0);
        check_eq("mid_rst_valid", 36'(out_valid), 36'd0);
        check_eq("mid_rst_proto", 36'(err_proto), 36'd0);
        send(9'h1AB);
        send(9'h1CD);
        idle(1);
        check_eq("mid_proto", 36'(err_proto), 36'd1);
        check_eq("mid_no_busy", 36'(busy), 36'd0);
        check_eq("mid_no_word", 36'(out_valid), 36'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
